uart_tx_packet_arbiter: RTL and testbench

- Shares the single host-bound UART TX byte stream between NUM_SRC independent 16-byte packet producers, such as the TileLink response bridge and status/telemetry packers.
- Arbitration between producers is round-robin.
- Each granted 128-bit packet is latched, then serialized LSB byte first (byte 0 = data[7:0]) onto a valid/ready byte interface that feeds the UART transmitter.
- Sits between the packet producers and the UART TX FIFO, all in the clk domain.

---
 rtl/uart_tx_packet_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_packet_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_packet_arbiter.sv
// Round-robin arbiter that serializes 128-bit packets onto a UART TX byte stream.
// Optional trailing XOR checksum byte: define UART_TX_ARB_CHECKSUM_EN.
module uart_tx_packet_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int SRC_W   = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SRC-1:0]     src_valid,
  output logic [NUM_SRC-1:0]     src_ready,
  input  logic [NUM_SRC*128-1:0] src_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic                   busy,
  output logic [SRC_W-1:0]       grant_id,
  output logic [15:0]            pkt_count
);

  typedef enum logic [1:0] {
    IDLE,
    SEND
`ifdef UART_TX_ARB_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] buf_q, buf_d;
  logic [3:0]   idx_q, idx_d;
  logic [SRC_W-1:0] last_q, last_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic         tx_valid_q, tx_valid_d;
  logic [7:0]   tx_data_q, tx_data_d;
  logic         busy_q, busy_d;
  logic [15:0]  cnt_q, cnt_d;

  logic               win_found;
  logic [SRC_W-1:0]   win_idx;
  logic [NUM_SRC-1:0] win_vec;
  logic [127:0]       win_data;
  logic [3:0]         idx_nx;
  logic [7:0]         next_byte;
  logic               tx_fire;

`ifdef UART_TX_ARB_CHECKSUM_EN
  logic [7:0] csum;

  // XOR of all sixteen latched packet bytes
  always_comb begin
    csum = '0;
    for (int b = 0; b < 16; b++) begin
      csum = csum ^ buf_q[8*b +: 8];
    end
  end
`endif

  // Round-robin search: first valid above last grant, else wrap from 0
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!win_found && src_valid[i] && (SRC_W'(i) > last_q)) begin
        win_found = 1'b1;
        win_idx   = SRC_W'(i);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!win_found && src_valid[i] && (SRC_W'(i) <= last_q)) begin
        win_found = 1'b1;
        win_idx   = SRC_W'(i);
      end
    end
  end

  // Winner one-hot vector and packet mux
  always_comb begin
    win_vec  = '0;
    win_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win_found && (win_idx == SRC_W'(i))) begin
        win_vec[i] = 1'b1;
        win_data   = src_data[128*i +: 128];
      end
    end
  end

  assign idx_nx    = idx_q + 4'd1;
  assign next_byte = buf_q[{idx_nx, 3'b000} +: 8];
  assign tx_fire   = tx_valid_q && tx_ready;

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    last_d     = last_q;
    grant_d    = grant_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    src_ready  = '0;
    unique case (state_q)
      IDLE: begin
        src_ready = win_vec & {NUM_SRC{reset_n}};
        if (win_found) begin
          buf_d      = win_data;
          grant_d    = win_idx;
          last_d     = win_idx;
          idx_d      = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = win_data[7:0];
          busy_d     = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_fire) begin
          if (idx_q == 4'hF) begin
`ifdef UART_TX_ARB_CHECKSUM_EN
            tx_data_d = csum;
            idx_d     = '0;
            state_d   = CSUM;
`else
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
            busy_d     = 1'b0;
            idx_d      = '0;
            cnt_d      = cnt_q + 16'd1;
            state_d    = IDLE;
`endif
          end else begin
            idx_d     = idx_nx;
            tx_data_d = next_byte;
          end
        end
      end
`ifdef UART_TX_ARB_CHECKSUM_EN
      CSUM: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          tx_data_d  = '0;
          busy_d     = 1'b0;
          cnt_d      = cnt_q + 16'd1;
          state_d    = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      idx_q      <= '0;
      last_q     <= SRC_W'(NUM_SRC - 1);
      grant_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_uart_tx_packet_arbiter.sv
// Directed self-checking bench for uart_tx_packet_arbiter.
// Checksum byte checks are active when UART_TX_ARB_CHECKSUM_EN is defined.
module tb_uart_tx_packet_arbiter;

  localparam int NUM_SRC = 2;
  localparam int SRC_W   = 3;
`ifdef UART_TX_ARB_CHECKSUM_EN
  localparam int FRAME = 17;
`else
  localparam int FRAME = 16;
`endif

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NUM_SRC-1:0] src_valid;
  logic [NUM_SRC-1:0] src_ready;
  logic [255:0]       src_data;
  logic               tx_valid;
  logic               tx_ready;
  logic [7:0]         tx_data;
  logic               busy;
  logic [SRC_W-1:0]   grant_id;
  logic [15:0]        pkt_count;

  int checks = 0;
  int errors = 0;

  logic [127:0] d0;
  logic [127:0] d1;
  logic [7:0]   exp_b;
  int e;
  int cyc;

  uart_tx_packet_arbiter #(
    .NUM_SRC(NUM_SRC),
    .SRC_W  (SRC_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .src_data (src_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .busy     (busy),
    .grant_id (grant_id),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Grant from IDLE then stream the full frame with tx_ready high
  task automatic send_pkt(input int g, input logic [127:0] d,
                          input logic [7:0] cs);
    chk("rr_ready", 32'(src_ready), 32'(1 << g));
    step();
    for (int b = 0; b < 16; b++) begin
      chk("pkt_valid", 32'(tx_valid), 32'd1);
      chk("pkt_byte", 32'(tx_data), 32'(d[8*b +: 8]));
      chk("pkt_gid", 32'(grant_id), 32'(g));
      chk("pkt_busy", 32'(busy), 32'd1);
      step();
    end
`ifdef UART_TX_ARB_CHECKSUM_EN
    chk("csum_valid", 32'(tx_valid), 32'd1);
    chk("csum_byte", 32'(tx_data), 32'(cs));
    step();
`else
    chk("csum_unused", 32'(cs & 8'h00), 32'd0);
`endif
    chk("gap_valid", 32'(tx_valid), 32'd0);
    chk("gap_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    d0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    d1 = 128'h8F8E8D8C_8B8A8988_87868584_83828180;
    reset_n   = 1'b0;
    src_valid = 2'b11;
    tx_ready  = 1'b1;
    src_data  = {d1, d0};

    // Reset held with both sources requesting
    repeat (3) begin
      step();
      chk("rst_ready", 32'(src_ready), 32'd0);
      chk("rst_txv", 32'(tx_valid), 32'd0);
      chk("rst_cnt", 32'(pkt_count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
    end
    reset_n = 1'b1;
    #1;
    chk("first_grant", 32'(src_ready), 32'h1);

    // Single packet from source 0
    src_valid = 2'b01;
    #1;
    send_pkt(0, d0, 8'h00);
    src_valid = 2'b00;
    chk("single_cnt", 32'(pkt_count), 32'd1);

    // Backpressure with tx_ready pattern 1,0,0 repeating
    src_valid = 2'b01;
    #1;
    chk("bp_ready", 32'(src_ready), 32'h1);
    step();
    src_valid = 2'b00;
    e = 0;
    cyc = 0;
    while (e < FRAME && cyc < 200) begin
      tx_ready = (cyc % 3 == 0);
      exp_b = (e < 16) ? d0[8*e +: 8] : 8'h00;
      chk("bp_valid", 32'(tx_valid), 32'd1);
      chk("bp_byte", 32'(tx_data), 32'(exp_b));
      step();
      if (tx_ready) e++;
      cyc++;
    end
    tx_ready = 1'b1;
    chk("bp_done", 32'(e), 32'(FRAME));
    chk("bp_end_valid", 32'(tx_valid), 32'd0);
    chk("bp_cnt", 32'(pkt_count), 32'd2);

    // Reset after byte 5 of a source 1 packet
    src_valid = 2'b10;
    #1;
    chk("mid_ready", 32'(src_ready), 32'h2);
    step();
    src_valid = 2'b00;
    for (int b = 0; b < 6; b++) begin
      chk("mid_byte", 32'(tx_data), 32'(d1[8*b +: 8]));
      chk("mid_gid", 32'(grant_id), 32'd1);
      step();
    end
    reset_n = 1'b0;
    step();
    chk("mid_txv", 32'(tx_valid), 32'd0);
    chk("mid_cnt", 32'(pkt_count), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_gid0", 32'(grant_id), 32'd0);
    reset_n = 1'b1;

    // Round-robin: both valid for four packets, fresh start at source 0
    src_valid = 2'b11;
    #1;
    send_pkt(0, d0, 8'h00);
    send_pkt(1, d1, 8'h00);
    send_pkt(0, d0, 8'h00);
    send_pkt(1, d1, 8'h00);
    src_valid = 2'b00;
    chk("rr_cnt", 32'(pkt_count), 32'd4);

`ifdef UART_TX_ARB_CHECKSUM_EN
    // Checksum corner patterns
    d0 = {16{8'hA5}};
    src_data = {d1, d0};
    src_valid = 2'b01;
    #1;
    send_pkt(0, d0, 8'h00);
    src_valid = 2'b00;
    d0 = 128'h1;
    src_data = {d1, d0};
    src_valid = 2'b01;
    #1;
    send_pkt(0, d0, 8'h01);
    src_valid = 2'b00;
    chk("cs_cnt", 32'(pkt_count), 32'd6);
`endif

    step();
    chk("idle_txv", 32'(tx_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
